// File: rtl/sram_1p_march_bist_ctrl.sv
// March C- BIST sequencer for the single-port bit-masked SRAM macro BIST port.
// It drives one op per cycle through registered outputs. Reads travel down a
// short pipe to the cycle where A_DOUT is valid, and are compared there. The
// first mismatch is latched, and the run always completes.
module sram_1p_march_bist_ctrl #(
    parameter int P_ADDR_WIDTH = 9,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_READ_LAT   = 1
) (
    input  logic                    A_CLK,
    input  logic                    A_RESET_N,
    input  logic                    A_START,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_BUSY,
    output logic                    A_BIST_DONE,
    output logic                    A_BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS
);

    localparam int AW = P_ADDR_WIDTH;
    localparam int DW = P_DATA_WIDTH;
    localparam int PD = P_READ_LAT + 1;
    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q;

    // Sequencer position: the op that will be issued at the next edge.
    logic [2:0]    elem_q, elem_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ph_q, ph_d;

    // Registered macro-facing outputs and status.
    logic          en_q, men_q, wen_q, ren_q, busy_q, done_q;
    logic [AW-1:0] bist_addr_q;
    logic [DW-1:0] din_q, bm_q;
    logic          fail_q;
    logic [AW-1:0] fail_addr_q;
    logic [2:0]    fail_elem_q;
    logic [DW-1:0] fail_bits_q;

    // Read-compare pipe: valid, address, element and expected bit per stage.
    logic          pv_q [PD];
    logic [AW-1:0] pa_q [PD];
    logic [2:0]    pe_q [PD];
    logic          px_q [PD];

    logic          start_acc, issue, op_read, op_bit, elem_down, elem_last_op;
    logic          last_op, pipe_busy, mismatch;
    logic [AW-1:0] addr_end;
    logic [DW-1:0] exp_word;

    // Decode the current op and work out the sequencer position after it.
    always_comb begin
        start_acc    = A_START && ((state_q == S_IDLE) || (state_q == S_DONE));
        issue        = start_acc || (state_q == S_MARCH);
        // E0 is a single write, E5 a single read, E1..E4 are read-then-write.
        op_read      = (elem_q != 3'd0) && !ph_q;
        // Read: expect all-1 in E2/E4. Write: write all-1 in E1/E3.
        op_bit       = op_read ? ((elem_q == 3'd2) || (elem_q == 3'd4))
                               : ((elem_q == 3'd1) || (elem_q == 3'd3));
        elem_down    = (elem_q == 3'd3) || (elem_q == 3'd4);
        elem_last_op = ((elem_q == 3'd0) || (elem_q == 3'd5)) ? 1'b1 : ph_q;
        addr_end     = elem_down ? '0 : ADDR_MAX;
        last_op      = (elem_q == 3'd5) && (addr_q == ADDR_MAX);

        elem_d = elem_q;
        addr_d = addr_q;
        ph_d   = ph_q;
        if (!elem_last_op) begin
            ph_d = 1'b1;
        end else begin
            ph_d = 1'b0;
            if (addr_q == addr_end) begin
                // The element ends at the last address in its order. The next
                // element starts at its own first address, so the order is not
                // taken from the address that wrapped.
                elem_d = elem_q + 3'd1;
                addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
            end else begin
                addr_d = elem_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
            end
        end
        if (last_op) begin
            elem_d = '0;
            addr_d = '0;
            ph_d   = 1'b0;
        end
    end

    // Any read still travelling through the compare pipe.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < PD; i++) begin
            pipe_busy = pipe_busy | pv_q[i];
        end
        exp_word = px_q[PD-1] ? {DW{1'b1}} : {DW{1'b0}};
        mismatch = pv_q[PD-1] && (A_DOUT != exp_word);
    end

    // Main FSM: issue one op per cycle, drain the compare pipe, then hold DONE.
    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            en_q        <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            bist_addr_q <= '0;
            din_q       <= '0;
            bm_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (issue) begin
            en_q        <= 1'b1;
            men_q       <= 1'b1;
            wen_q       <= !op_read;
            ren_q       <= op_read;
            bist_addr_q <= addr_q;
            din_q       <= (!op_read && op_bit) ? {DW{1'b1}} : {DW{1'b0}};
            bm_q        <= {DW{1'b1}};
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            ph_q        <= ph_d;
            state_q     <= last_op ? S_DRAIN : S_MARCH;
        end else if (state_q == S_DRAIN) begin
            // Keep the port selected, but idle, until the last read has been compared.
            men_q <= 1'b0;
            wen_q <= 1'b0;
            ren_q <= 1'b0;
            din_q <= '0;
            if (!pipe_busy) begin
                state_q     <= S_DONE;
                en_q        <= 1'b0;
                bm_q        <= '0;
                bist_addr_q <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
            end
        end
    end

    // Read-compare pipe and first-failure capture. A new run clears both.
    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            for (int i = 0; i < PD; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
                pe_q[i] <= '0;
                px_q[i] <= 1'b0;
            end
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bits_q <= '0;
        end else if (start_acc) begin
            for (int i = 0; i < PD; i++) begin
                pv_q[i] <= 1'b0;
            end
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bits_q <= '0;
        end else begin
            pv_q[0] <= issue && op_read;
            pa_q[0] <= addr_q;
            pe_q[0] <= elem_q;
            px_q[0] <= op_bit;
            for (int i = 1; i < PD; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
                px_q[i] <= px_q[i-1];
            end
            if (mismatch && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= pa_q[PD-1];
                fail_elem_q <= pe_q[PD-1];
                fail_bits_q <= A_DOUT ^ exp_word;
            end
        end
    end

    assign A_BIST_EN   = en_q;
    assign A_BIST_MEN  = men_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_ADDR = bist_addr_q;
    assign A_BIST_DIN  = din_q;
    assign A_BIST_BM   = bm_q;
    assign A_BIST_BUSY = busy_q;
    assign A_BIST_DONE = done_q;
    assign A_BIST_FAIL = fail_q;
    assign A_FAIL_ADDR = fail_addr_q;
    assign A_FAIL_ELEM = fail_elem_q;
    assign A_FAIL_BITS = fail_bits_q;

endmodule

// File: tb/tb_sram_1p_march_bist_ctrl.sv
// Testbench for sram_1p_march_bist_ctrl. It models the macro, including
// injectable faults. Each run's expected op stream and result come from the
// march algorithm description and are queued. Separate monitors pop and
// compare them as the DUT presents ops and DONE.
module tb_sram_1p_march_bist_ctrl;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int N   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dout = '0;

    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic          A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL;
    logic [AW-1:0] A_FAIL_ADDR;
    logic [2:0]    A_FAIL_ELEM;
    logic [DW-1:0] A_FAIL_BITS;

    sram_1p_march_bist_ctrl #(
        .P_ADDR_WIDTH(AW),
        .P_DATA_WIDTH(DW),
        .P_READ_LAT  (LAT)
    ) dut (
        .A_CLK      (clk),
        .A_RESET_N  (rst_n),
        .A_START    (start),
        .A_DOUT     (dout),
        .A_BIST_EN  (A_BIST_EN),
        .A_BIST_MEN (A_BIST_MEN),
        .A_BIST_WEN (A_BIST_WEN),
        .A_BIST_REN (A_BIST_REN),
        .A_BIST_ADDR(A_BIST_ADDR),
        .A_BIST_DIN (A_BIST_DIN),
        .A_BIST_BM  (A_BIST_BM),
        .A_BIST_BUSY(A_BIST_BUSY),
        .A_BIST_DONE(A_BIST_DONE),
        .A_BIST_FAIL(A_BIST_FAIL),
        .A_FAIL_ADDR(A_FAIL_ADDR),
        .A_FAIL_ELEM(A_FAIL_ELEM),
        .A_FAIL_BITS(A_FAIL_BITS)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct {
        longint        done_edge;
        logic          fail;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
        logic [DW-1:0] bits;
    } res_t;

    op_t    op_q[$];
    res_t   res_q[$];
    int     checks = 0;
    int     failures = 0;
    longint edge_cnt = 0;
    int     busy_gap = 0;
    bit     run_active = 1'b0;
    int     run_id = 0;

    // Fault model: 0 none, 1 stuck-at (fa, fb, fv), 2 coupling (write addr 3 flips addr 2 bit 0).
    int     fault_kind = 0;
    int     fa = 0;
    int     fb = 0;
    logic   fv = 1'b0;

    // mem0 is the reference model's array; mem1 is the macro's array.
    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] mem1 [N];

    function automatic void mem_wr(input bit m, input int a, input logic [DW-1:0] d);
        if (m) mem1[a] = d;
        else   mem0[a] = d;
        if (fault_kind == 2 && a == 3) begin
            if (m) mem1[2][0] = ~mem1[2][0];
            else   mem0[2][0] = ~mem0[2][0];
        end
    endfunction

    function automatic logic [DW-1:0] mem_rd(input bit m, input int a);
        logic [DW-1:0] v;
        v = m ? mem1[a] : mem0[a];
        if (fault_kind == 1 && a == fa) v[fb] = fv;
        return v;
    endfunction

    // March C-: 0=w0 1=w1 2=r0 3=r1, -1 = no second op in this element.
    function automatic int op_code(input int e, input int j);
        case (e)
            0:       return (j == 0) ? 0 : -1;
            1, 3:    return (j == 0) ? 2 : 1;
            2, 4:    return (j == 0) ? 3 : 0;
            default: return (j == 0) ? 2 : -1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Macro model: a write or read is captured at the edge; read data is registered.
    always @(posedge clk) begin
        if (A_BIST_EN && A_BIST_MEN) begin
            if (A_BIST_WEN) mem_wr(1'b1, int'(A_BIST_ADDR), A_BIST_DIN);
            if (A_BIST_REN) dout <= mem_rd(1'b1, int'(A_BIST_ADDR));
        end
    end

    // Walk the march over the reference array, queue every op, and work out the first failure.
    task automatic build_run(output res_t r);
        logic [DW-1:0] got, expv, data;
        int a, c;
        op_t o;
        r.done_edge = 0;
        r.fail = 1'b0;
        r.addr = '0;
        r.elem = '0;
        r.bits = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? (N - 1 - i) : i;
                for (int j = 0; j < 2; j++) begin
                    c = op_code(e, j);
                    if (c < 0) continue;
                    o.addr = AW'(a);
                    if (c < 2) begin
                        data = (c == 1) ? {DW{1'b1}} : {DW{1'b0}};
                        o.we = 1'b1;
                        o.din = data;
                        op_q.push_back(o);
                        mem_wr(1'b0, a, data);
                    end else begin
                        expv = (c == 3) ? {DW{1'b1}} : {DW{1'b0}};
                        o.we = 1'b0;
                        o.din = '0;
                        op_q.push_back(o);
                        got = mem_rd(1'b0, a);
                        if (got !== expv && !r.fail) begin
                            r.fail = 1'b1;
                            r.addr = AW'(a);
                            r.elem = 3'(e);
                            r.bits = got ^ expv;
                        end
                    end
                end
            end
        end
    endtask

    // Op monitor: every enabled cycle must match the next queued op.
    initial begin : op_mon
        op_t o;
        forever begin
            @(negedge clk);
            if (rst_n && A_BIST_MEN) begin
                if (op_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL op_unexpected addr=%0h required=no_op", A_BIST_ADDR);
                end else begin
                    o = op_q.pop_front();
                    chk("op", {A_BIST_EN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR,
                               (A_BIST_WEN ? A_BIST_DIN : {DW{1'b0}}), A_BIST_BM},
                              {1'b1, o.we, !o.we, o.addr, o.din, {DW{1'b1}}});
                end
            end
        end
    end

    // Result monitor: on a rising DONE, pop and compare the run's expected result.
    initial begin : done_mon
        res_t r;
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (run_active && rst_n && !A_BIST_DONE && !(A_BIST_BUSY && A_BIST_EN)) busy_gap++;
            if (rst_n && A_BIST_DONE && !done_prev) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected edge=%0d required=no_done", edge_cnt);
                end else begin
                    r = res_q.pop_front();
                    chk("done_edge", edge_cnt, r.done_edge);
                    chk("fail_flag", A_BIST_FAIL, r.fail);
                    chk("fail_addr", A_FAIL_ADDR, r.addr);
                    chk("fail_elem", A_FAIL_ELEM, r.elem);
                    chk("fail_bits", A_FAIL_BITS, r.bits);
                    chk("busy_gap", busy_gap, 0);
                    chk("idle_after_done", {A_BIST_EN, A_BIST_BUSY, A_BIST_MEN, A_BIST_BM}, 0);
                    chk("ops_left", op_q.size(), 0);
                    $display("run %0d fault=%0d done_edge=%0d fail=%0b addr=%0h elem=%0d bits=%08h",
                             run_id, fault_kind, edge_cnt, A_BIST_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_BITS);
                end
            end
            done_prev = A_BIST_DONE;
        end
    end

    task automatic start_run();
        res_t r;
        @(negedge clk);
        start = 1'b1;
        build_run(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        r.done_edge = edge_cnt + 10 * N + LAT + 1;
        busy_gap = 0;
        run_active = 1'b1;
        run_id++;
        res_q.push_back(r);
        chk("start_state", {A_BIST_DONE, A_BIST_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_BITS,
                            A_BIST_BUSY, A_BIST_EN}, {2'b00, {AW{1'b0}}, 3'b000, {DW{1'b0}}, 2'b11});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!A_BIST_DONE && n < 12000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!A_BIST_DONE) begin
            checks++;
            failures++;
            $display("FAIL done_timeout cycles=%0d required=%0d", n, 10 * N + LAT + 1);
            res_q.delete();
            op_q.delete();
        end
        @(negedge clk);
        #1;
        run_active = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
                   A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_FAIL_ADDR, A_FAIL_ELEM, A_FAIL_BITS}, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem1[i] = $urandom;
            mem0[i] = mem1[i];
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free march
        fault_kind = 0;
        start_run();
        wait_done();

        // Bit 5 stuck-at-1 at 0x1A5
        fault_kind = 1; fa = 'h1A5; fb = 5; fv = 1'b1;
        start_run();
        wait_done();

        // Coupling fault; start from DONE with FAIL set must clear the results
        fault_kind = 2;
        start_run();
        wait_done();

        // Randomised stuck-at faults
        for (int k = 0; k < 2; k++) begin
            fault_kind = 1;
            fa = int'($urandom_range(0, N - 1));
            fb = int'($urandom_range(0, DW - 1));
            fv = 1'($urandom_range(0, 1));
            start_run();
            wait_done();
        end

        // START pulsed while busy is ignored
        fault_kind = 0;
        start_run();
        repeat (100) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Asynchronous reset mid-run, then a full run
        start_run();
        repeat (2000) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset_outputs");
        run_active = 1'b0;
        op_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run();
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
